// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU codes, FSM states, PC controls and trap causes for ctrl_fsm_mc
package ctrl_pkg;
   localparam logic [3:0] OP_LDRI = 4'hA, OP_STR = 4'hB, OP_JMP = 4'hC, OP_JZ = 4'hD,
                          OP_HALT = 4'hE, OP_ILLEGAL = 4'hF;
   localparam logic [2:0] ALU_MOV = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3, ALU_OR = 3'd4;
   localparam logic [1:0] PC_HOLD = 2'b00, PC_INC = 2'b01, PC_LOAD = 2'b10;
   localparam logic [1:0] TC_NONE = 2'b00, TC_IF = 2'b01, TC_EX = 2'b10, TC_MEM = 2'b11;
   typedef enum logic [2:0] {S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_TRAP} state_t;
   function automatic logic is_alu(input logic [3:0] op);
      return op <= 4'd9;
   endfunction
endpackage

// File: rtl/ctrl_fsm_mc_if.sv
// ctrl_fsm_mc_if: handshake inputs and datapath controls between the controller (master) and datapath (slave)
interface ctrl_fsm_mc_if #(parameter int REG_ADDR_W = 2);
   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   logic                  en_in, fetch_done, alu_done, mem_done, zero_flag, clr_trap;
   logic [3:0]            opcode;
   logic [REG_ADDR_W-1:0] rd;
   logic                  en_fetch_pulse, en_pc_pulse, en_group_pulse;
   logic [1:0]            pc_ctrl;
   logic [NUM_REGS-1:0]   reg_en;
   logic                  ldr_sel, alu_in_sel, en_str, en_ldr;
   logic [2:0]            alu_func;
   logic                  halted, trap;
   logic [1:0]            trap_cause;
   modport master (
      input  en_in, fetch_done, alu_done, mem_done, zero_flag, clr_trap, opcode, rd,
      output en_fetch_pulse, en_pc_pulse, en_group_pulse, pc_ctrl, reg_en, ldr_sel, alu_in_sel,
             en_str, en_ldr, alu_func, halted, trap, trap_cause
   );
   modport slave (
      output en_in, fetch_done, alu_done, mem_done, zero_flag, clr_trap, opcode, rd,
      input  en_fetch_pulse, en_pc_pulse, en_group_pulse, pc_ctrl, reg_en, ldr_sel, alu_in_sel,
             en_str, en_ldr, alu_func, halted, trap, trap_cause
   );
endinterface

// File: rtl/ctrl_watchdog.sv
// ctrl_watchdog: counts cycles waited for a done; flags timeout once WAIT_MAX cycles have passed
module ctrl_watchdog #(parameter int WAIT_MAX = 15) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   input  logic done,
   output logic timeout
);
   localparam int W = WAIT_MAX > 0 ? $clog2(WAIT_MAX + 1) : 1;
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (count_en && !done) cnt <= cnt + W'(1);
   // a done arriving in the same cycle suppresses the timeout
   assign timeout = WAIT_MAX != 0 && count_en && !done && int'(cnt) == WAIT_MAX;
endmodule

// File: rtl/ctrl_fsm_mc.sv
// ctrl_fsm_mc: multicycle controller sequencing IF/ID/EX/MEM/WB with HALT, JZ and a watchdog trap
module ctrl_fsm_mc import ctrl_pkg::*; #(
   parameter int REG_ADDR_W = 2,
   parameter int WAIT_MAX   = 15
) (
   input logic          clk,
   input logic          rst_n,
   ctrl_fsm_mc_if.master bus
);
   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   state_t     state, state_nxt;
   logic       entry, timeout, count_en, done, alu, ex, jmp_go;
   logic [1:0] cause, cause_nxt;
   logic [3:0] op;
   assign op = bus.opcode;
   assign alu = is_alu(op);
   assign ex = state == S_EX;
   assign jmp_go = op == OP_JMP || (op == OP_JZ && bus.zero_flag);
   always_comb begin
      count_en = state == S_IF || (ex && alu) || state == S_MEM;
      done = state == S_IF ? bus.fetch_done : ex ? bus.alu_done : bus.mem_done;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  state_nxt = bus.en_in ? S_IF : S_INIT;
         S_IF:    state_nxt = bus.fetch_done ? S_ID : timeout ? S_TRAP : S_IF;
         S_ID:    state_nxt = alu || op == OP_STR || op == OP_JMP || op == OP_JZ ? S_EX :
                              op == OP_LDRI ? S_MEM : op == OP_ILLEGAL ? S_TRAP : S_HALT;
         S_EX:    state_nxt = !alu ? (op == OP_STR ? S_MEM : S_IF) :
                              bus.alu_done ? S_WB : timeout ? S_TRAP : S_EX;
         S_MEM:   state_nxt = bus.mem_done ? (op == OP_LDRI ? S_WB : S_IF) : timeout ? S_TRAP : S_MEM;
         S_WB:    state_nxt = S_IF;
         S_HALT:  state_nxt = bus.en_in ? S_IF : S_HALT;
         S_TRAP:  state_nxt = bus.clr_trap ? S_INIT : S_TRAP;
         default: state_nxt = S_INIT;
      endcase
   end
   // the only way into TRAP from MEM or ID shares cause 11
   assign cause_nxt = state == S_TRAP ? (state_nxt == S_TRAP ? cause : TC_NONE) :
                      state_nxt == S_TRAP ? (state == S_IF ? TC_IF : ex ? TC_EX : TC_MEM) : cause;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= S_INIT;
         entry <= 1'b0;
         cause <= TC_NONE;
      end else begin
         state <= state_nxt;
         entry <= state_nxt != state;
         cause <= cause_nxt;
      end
   ctrl_watchdog #(.WAIT_MAX(WAIT_MAX)) u_wd (
      .clk(clk), .rst_n(rst_n), .clear(state_nxt != state),
      .count_en(count_en), .done(done), .timeout(timeout)
   );
   always_comb begin
      bus.pc_ctrl = state == S_IF ? PC_INC : ex && jmp_go ? PC_LOAD : PC_HOLD;
      bus.alu_func = ex && alu ? op[3:1] : 3'b000;
      bus.alu_in_sel = ex && alu && op[0];
      bus.en_ldr = state == S_MEM && op == OP_LDRI;
      bus.ldr_sel = (state == S_MEM || state == S_WB) && op == OP_LDRI;
      bus.en_str = state == S_MEM && op == OP_STR;
      bus.reg_en = state == S_WB ? NUM_REGS'(1) << bus.rd : '0;
      bus.halted = state == S_HALT;
      bus.trap = state == S_TRAP;
      bus.trap_cause = cause;
      bus.en_fetch_pulse = entry && state == S_IF;
      bus.en_pc_pulse = entry && (state == S_IF || (ex && jmp_go));
      bus.en_group_pulse = entry && ex;
   end
endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// tb_ctrl_fsm_mc: directed instruction sequences; per-cycle expected outputs queued and checked by a monitor
module tb_ctrl_fsm_mc;
   import ctrl_pkg::*;
   typedef struct packed {
      logic       fp, pp, gp;
      logic [1:0] pc;
      logic [7:0] re;
      logic       ls, ai, st, ld;
      logic [2:0] fn;
      logic       h, t;
      logic [1:0] tc;
   } out_t;
   localparam out_t Z = '0;
   localparam logic [5:0] EN = 6'b100000, FD = 6'b010000, AD = 6'b001000, MD = 6'b000100,
                          ZF = 6'b000010, CT = 6'b000001, DN = FD | AD | MD;
   localparam logic [3:0] MOVI = 4'b0000, ADDI = 4'b0010, ADDR = 4'b0011;
   logic clk = 1'b0, rst_n = 1'b0;
   int   passed = 0, total = 0;
   out_t exp_q[$];
   string name_q[$];
   out_t got, mon_e;
   string mon_n;
   ctrl_fsm_mc_if #(.REG_ADDR_W(3)) bus ();
   ctrl_fsm_mc #(.REG_ADDR_W(3), .WAIT_MAX(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
   always #5 clk = ~clk;
   assign got = {bus.en_fetch_pulse, bus.en_pc_pulse, bus.en_group_pulse, bus.pc_ctrl, bus.reg_en,
                 bus.ldr_sel, bus.alu_in_sel, bus.en_str, bus.en_ldr, bus.alu_func,
                 bus.halted, bus.trap, bus.trap_cause};
   always @(negedge clk)
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_n = name_q.pop_front();
         total++;
         if (got !== mon_e) $display("FAIL %s: got %h expected %h", mon_n, got, mon_e);
         else passed++;
      end
   function automatic out_t f_if(input logic first);
      out_t o = Z;
      o.fp = first; o.pp = first; o.pc = PC_INC;
      return o;
   endfunction
   function automatic out_t f_ex_alu(input logic first, input logic [2:0] fn, input logic ai);
      out_t o = Z;
      o.gp = first; o.fn = fn; o.ai = ai;
      return o;
   endfunction
   function automatic out_t f_ex_j(input logic taken);
      out_t o = Z;
      o.gp = 1'b1; o.pp = taken; o.pc = taken ? PC_LOAD : PC_HOLD;
      return o;
   endfunction
   function automatic out_t f_mem(input logic ldri);
      out_t o = Z;
      o.ld = ldri; o.ls = ldri; o.st = !ldri;
      return o;
   endfunction
   function automatic out_t f_wb(input int r, input logic ldri);
      out_t o = Z;
      o.re = 8'(1 << r); o.ls = ldri;
      return o;
   endfunction
   function automatic out_t f_st(input logic h, input logic [1:0] tc);
      out_t o = Z;
      o.h = h; o.t = !h; o.tc = tc;
      return o;
   endfunction
   task automatic cyc(input string nm, input logic [3:0] op, input logic [2:0] r,
                      input logic [5:0] iv, input out_t e);
      @(posedge clk);
      #1;
      bus.opcode = op;
      bus.rd = r;
      {bus.en_in, bus.fetch_done, bus.alu_done, bus.mem_done, bus.zero_flag, bus.clr_trap} = iv;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask
   initial begin
      {bus.en_in, bus.fetch_done, bus.alu_done, bus.mem_done, bus.zero_flag, bus.clr_trap} = '0;
      bus.opcode = '0;
      bus.rd = '0;
      cyc("reset", MOVI, 0, 0, Z);
      total++;
      if (dut.state !== S_INIT || got !== Z) $display("FAIL reset_state: state %0d outputs %h", dut.state, got);
      else passed++;
      rst_n = 1'b1;
      cyc("init_idle", MOVI, 0, 0, Z);
      cyc("init_go", MOVI, 0, EN | DN, Z);
      cyc("addi_if", ADDI, 5, DN, f_if(1));
      cyc("addi_id", ADDI, 5, DN, Z);
      cyc("addi_ex", ADDI, 5, DN, f_ex_alu(1, ALU_ADD, 0));
      cyc("addi_wb", ADDI, 5, DN, f_wb(5, 0));
      cyc("ldri_if", OP_LDRI, 2, DN, f_if(1));
      cyc("ldri_id", OP_LDRI, 2, FD | AD, Z);
      cyc("ldri_mem0", OP_LDRI, 2, FD | AD, f_mem(1));
      cyc("ldri_mem1", OP_LDRI, 2, FD | AD, f_mem(1));
      cyc("ldri_mem2", OP_LDRI, 2, FD | AD, f_mem(1));
      cyc("ldri_mem3", OP_LDRI, 2, DN, f_mem(1));
      cyc("ldri_wb", OP_LDRI, 2, DN, f_wb(2, 1));
      cyc("jz_t_if", OP_JZ, 0, DN | ZF, f_if(1));
      cyc("jz_t_id", OP_JZ, 0, DN | ZF, Z);
      cyc("jz_t_ex", OP_JZ, 0, DN | ZF, f_ex_j(1));
      cyc("jz_n_if", OP_JZ, 0, DN, f_if(1));
      cyc("jz_n_id", OP_JZ, 0, DN, Z);
      cyc("jz_n_ex", OP_JZ, 0, DN, f_ex_j(0));
      cyc("jmp_if", OP_JMP, 0, DN, f_if(1));
      cyc("jmp_id", OP_JMP, 0, DN, Z);
      cyc("jmp_ex", OP_JMP, 0, DN, f_ex_j(1));
      cyc("add_if", ADDR, 1, DN, f_if(1));
      cyc("add_id", ADDR, 1, FD | MD, Z);
      cyc("add_ex0", ADDR, 1, FD | MD, f_ex_alu(1, ALU_ADD, 1));
      cyc("add_ex1", ADDR, 1, FD | MD, f_ex_alu(0, ALU_ADD, 1));
      cyc("add_ex2", ADDR, 1, FD | MD, f_ex_alu(0, ALU_ADD, 1));
      cyc("add_ex3", ADDR, 1, FD | MD, f_ex_alu(0, ALU_ADD, 1));
      cyc("trap_ex_hold", ADDR, 1, EN | DN, f_st(0, TC_EX));
      total++;
      if (dut.state !== S_TRAP || bus.trap !== 1'b1 || bus.trap_cause !== TC_EX)
         $display("FAIL expired_wait: state %0d trap %b cause %b", dut.state, bus.trap, bus.trap_cause);
      else passed++;
      cyc("trap_ex_clr", ADDR, 1, CT, f_st(0, TC_EX));
      cyc("init_after_trap", OP_HALT, 0, EN | DN, Z);
      cyc("halt_if", OP_HALT, 0, DN, f_if(1));
      cyc("halt_id", OP_HALT, 0, 0, Z);
      cyc("halt0", OP_HALT, 0, 0, f_st(1, TC_NONE));
      cyc("halt1", OP_HALT, 0, EN, f_st(1, TC_NONE));
      cyc("ill_if0", OP_ILLEGAL, 0, 0, f_if(1));
      cyc("ill_if1", OP_ILLEGAL, 0, FD, f_if(0));
      cyc("ill_id", OP_ILLEGAL, 0, 0, Z);
      cyc("trap_ill", OP_ILLEGAL, 0, CT, f_st(0, TC_MEM));
      cyc("init_after_ill", OP_STR, 0, EN | DN, Z);
      cyc("str_if", OP_STR, 0, DN, f_if(1));
      cyc("str_id", OP_STR, 0, DN, Z);
      cyc("str_ex", OP_STR, 0, DN, f_ex_alu(1, ALU_MOV, 0));
      cyc("str_mem", OP_STR, 0, DN, f_mem(0));
      cyc("movi_if", MOVI, 7, DN, f_if(1));
      cyc("movi_id", MOVI, 7, DN, Z);
      cyc("movi_ex", MOVI, 7, DN, f_ex_alu(1, ALU_MOV, 0));
      cyc("movi_wb_rst", MOVI, 7, DN, Z);
      rst_n = 1'b0;
      cyc("rst_hold", MOVI, 7, DN, Z);
      rst_n = 1'b1;
      cyc("init_after_rst", MOVI, 7, 0, Z);
      cyc("init_go2", MOVI, 7, EN | DN, Z);
      cyc("if_after_rst", MOVI, 7, DN, f_if(1));
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
